// File: rtl/metadata_stream_arbiter_pkg.sv
// rtl/metadata_stream_arbiter_pkg.sv - shared encodings for the metadata stream blocks
package metadata_stream_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PKT  = 2'd2
  } arb_state_t;

  localparam int SRC_PORT_POS = 16;
  localparam int SRC_PORT_W   = 8;
  localparam int CNT_W        = 32;

  // Source tag written into tuser: two bits per port so sibling blocks can OR tags.
  function automatic logic [SRC_PORT_W-1:0] src_code(input logic [1:0] port);
    return 8'h01 << {port, 1'b0};
  endfunction

endpackage

// File: rtl/rr_grant_select.sv
// rtl/rr_grant_select.sv - round-robin pick of the next requester after last_grant
module rr_grant_select #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    // Walk last_grant+1 .. last_grant+N so the previous winner is considered last.
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % N);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/metadata_stream_arbiter.sv
// rtl/metadata_stream_arbiter.sv - packet-atomic round-robin merge of metadata streams
module metadata_stream_arbiter
  import metadata_stream_arbiter_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS          = 4
) (
  input  logic                                      axi_aclk,
  input  logic                                      axi_reset,
  input  logic                                      sw_rst,
  input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
  output logic [NUM_PORTS-1:0]                      s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic                                      m_axis_tvalid,
  output logic                                      m_axis_tlast,
  input  logic                                      m_axis_tready,
  input  logic [NUM_PORTS-1:0]                      port_enable,
  output logic [NUM_PORTS*CNT_W-1:0]                pkt_count,
  output logic                                      err_hdr_tlast
);

  localparam int IDX_W  = $clog2(NUM_PORTS);
  localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;

  logic [C_AXIS_DATA_WIDTH-1:0]  tdata_a [NUM_PORTS];
  logic [STRB_W-1:0]             tstrb_a [NUM_PORTS];
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_a [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign tdata_a[i] = s_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
    assign tstrb_a[i] = s_axis_tstrb[i*STRB_W +: STRB_W];
    assign tuser_a[i] = s_axis_tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
  end

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic                   err_q, err_d;
  logic [NUM_PORTS*CNT_W-1:0] cnt_q, cnt_d;
  logic                   cnt_inc;
  logic                   handshake;
  logic                   active;
  logic [IDX_W-1:0]       sel_grant;
  logic                   sel_valid;
  logic [1:0]             src_idx;
  logic                   rst;

  assign rst           = axi_reset | sw_rst;
  assign src_idx       = 2'(grant_q);
  assign pkt_count     = cnt_q;
  assign err_hdr_tlast = err_q;

  rr_grant_select #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr_grant_select (
    .req        (s_axis_tvalid & port_enable),
    .last_grant (last_q),
    .grant      (sel_grant),
    .valid      (sel_valid)
  );

  // Zero-latency mux from the granted port; tvalid is independent of tready.
  always_comb begin
    active        = (state_q != ST_IDLE);
    m_axis_tdata  = tdata_a[grant_q];
    m_axis_tstrb  = tstrb_a[grant_q];
    m_axis_tuser  = tuser_a[grant_q];
    m_axis_tuser[SRC_PORT_POS +: SRC_PORT_W] = src_code(src_idx);
    m_axis_tlast  = s_axis_tlast[grant_q];
    m_axis_tvalid = active & s_axis_tvalid[grant_q];
    s_axis_tready = '0;
    if (active) s_axis_tready[grant_q] = m_axis_tready;
    handshake     = m_axis_tvalid & m_axis_tready;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    err_d   = err_q;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          grant_d = sel_grant;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (handshake) begin
          if (m_axis_tlast) begin
            // Malformed header-only packet: still forwarded and counted.
            state_d = ST_IDLE;
            err_d   = 1'b1;
            cnt_inc = 1'b1;
            last_d  = grant_q;
          end else begin
            state_d = ST_PKT;
          end
        end
      end
      ST_PKT: begin
        if (handshake && m_axis_tlast) begin
          state_d = ST_IDLE;
          cnt_inc = 1'b1;
          last_d  = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (cnt_inc && (grant_q == IDX_W'(p))) begin
        cnt_d[p*CNT_W +: CNT_W] = cnt_q[p*CNT_W +: CNT_W] + 32'd1;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_PORTS - 1);
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/metadata_stream_arbiter.md
METADATA_STREAM_ARBITER -- requirements
Module: metadata_stream_arbiter

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 512, tdata width of all ports.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128, tuser width of all ports.
REQ-003 SHALL have parameter NUM_PORTS, default 4 (legal 2..4), number of input streams.
REQ-004 SHALL have one clock and a synchronous, active-high reset: axi_aclk in 1, rising-edge clock; axi_reset in 1, synchronous, active-high.
REQ-005 SHALL have sw_rst in 1, synchronous active-high soft reset, equivalent to axi_reset.
REQ-006 SHALL have s_axis_tdata/tstrb/tuser/tvalid/tlast in, NUM_PORTS x width flattened, port i at slice i; s_axis_tready out NUM_PORTS.
REQ-007 SHALL have m_axis_tdata/tstrb/tuser/tvalid/tlast out, single port; m_axis_tready in 1.
REQ-008 SHALL have port_enable in NUM_PORTS, per-port arbitration enable.
REQ-009 SHALL have pkt_count out NUM_PORTS*32, per-port forwarded-packet counters.
REQ-010 SHALL have err_hdr_tlast out 1, sticky flag: header beat carried tlast.

Function
REQ-011 Each input packet SHALL be one metadata header beat (timestamp in tdata[31:0], tlast=0) followed by >=1 payload beats ending in tlast; header and payload SHALL be forwarded unmodified and contiguous.
REQ-012 FSM states SHALL be IDLE, HDR, PKT.
REQ-013 IDLE: grant SHALL go to the first port with tvalid=1 and port_enable=1, searching from (last_grant+1) mod NUM_PORTS; grant registered, FSM -> HDR next cycle; no handshake in IDLE (one bubble cycle per packet).
REQ-014 IDLE with no eligible port: grant and last_grant unchanged, stay IDLE.
REQ-015 HDR/PKT: m_axis_* SHALL combinationally mux granted port g; s_axis_tready[g]=m_axis_tready; all other s_axis_tready=0; zero-cycle latency.
REQ-016 HDR: handshake with tlast=0 -> PKT; handshake with tlast=1 -> IDLE, err_hdr_tlast set, packet counted.
REQ-017 PKT: handshake with tlast=1 -> IDLE, last_grant<=g, pkt_count[g] +1.
REQ-018 m_axis_tuser[23:16] SHALL be replaced on every beat by one-hot source code 1<<(2*g); all other tuser bits pass through.
REQ-019 pkt_count SHALL be 32-bit unsigned, wrapping 0xFFFFFFFF -> 0.
REQ-020 Deasserting port_enable[g] mid-packet SHALL NOT abort it; the packet completes, then port g is skipped.
REQ-021 m_axis_tvalid SHALL NOT depend on m_axis_tready; tvalid deassertion on the granted input mid-packet SHALL stall without releasing grant.
REQ-022 In IDLE all s_axis_tready and m_axis_tvalid SHALL be 0.

Reset
REQ-023 On axi_reset or sw_rst (including mid-packet): state IDLE, last_grant=NUM_PORTS-1 (port 0 first), grant=0, pkt_count all 0, err_hdr_tlast=0, all tready/tvalid 0 the following cycle.
REQ-024 Reset SHALL take priority over all handshakes in the same cycle.

Structure
REQ-025 State encodings and SRC_PORT_POS (16) SHALL live in a shared package used by sibling metadata blocks.
REQ-026 Round-robin selection SHALL be a sub-module rr_grant_select (request vector, last_grant -> grant index, valid).
REQ-027 Implementation SHALL be 120-400 lines RTL, no FIFOs.

Verification
REQ-028 Ports 0-3 each present one 3-beat packet (hdr+2) simultaneously, m_axis_tready=1 -> output order 0,1,2,3, 4 cycles each, tuser[23:16]=0x01,0x04,0x10,0x40, pkt_count each 1.
REQ-029 Port 1 header+payload, m_axis_tready toggling 1/0 -> no beat lost/duplicated, s_axis_tready[1] tracks m_axis_tready, other ports tready=0.
REQ-030 port_enable[2] cleared during beat 2 of port 2's 5-beat packet -> all 5 beats forwarded, next port 2 packet not granted while disabled.
REQ-031 Port 0 header beat with tlast=1 -> beat forwarded, err_hdr_tlast=1 held until reset, FSM returns IDLE, pkt_count[0]=1.
REQ-032 axi_reset asserted mid-PKT on port 3 -> next cycle all tready/tvalid 0, counters 0; after release, port 0 granted first.
REQ-033 pkt_count[1] preset via forced 0xFFFFFFFF, one packet on port 1 -> pkt_count[1]=0.
